// File: rtl/i2c_pkg.sv
// Types and widths shared by the I2C target and initiator state controls.
// No logic; only declarations.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV_ADDR,
    ST_DEV_ACK,
    ST_REG_ADDR,
    ST_REG_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_IGNORE
  } i2c_state_e;

endpackage

// File: rtl/i2c_bus_monitor.sv
// Synchronises raw SCL/SDA and emits single-cycle SCL edge and START/STOP pulses.
// Pulses appear 2 enabled cycles after the bus change; nothing advances while clk_en is low.
module i2c_bus_monitor (
  input  logic clk,
  input  logic sync_rst,
  input  logic clk_en,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda
);

  logic scl_s1, scl_s2, scl_d;
  logic sda_s1, sda_s2, sda_d;

  // Idle bus level is high, so every stage resets to 1.
  always_ff @(posedge clk) begin
    if (!sync_rst) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_d  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_d  <= 1'b1;
    end else if (clk_en) begin
      scl_s1 <= scl_in;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= sda_in;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
    end
  end

  assign scl_rise  = clk_en & scl_s2 & ~scl_d;
  assign scl_fall  = clk_en & ~scl_s2 & scl_d;
  assign start_det = clk_en & scl_s2 & scl_d & sda_d & ~sda_s2;
  assign stop_det  = clk_en & scl_s2 & scl_d & ~sda_d & sda_s2;
  assign sda       = sda_s2;

endmodule

// File: rtl/i2c_target_state_control.sv
// I2C target register-access FSM: address match, register pointer, byte write/read handshakes.
// Bus timing set by the controller's SCL; rd_data is taken two enabled cycles after rd_req.
module i2c_target_state_control
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = 7'h42
) (
  input  logic                  clk,
  input  logic                  sync_rst,
  input  logic                  clk_en,
  input  logic                  scl_in,
  input  logic                  sda_in,
  output logic                  sda_oe,
  output logic [I2C_BYTE_W-1:0] reg_addr,
  output logic                  wr_valid,
  output logic [I2C_BYTE_W-1:0] wr_data,
  output logic                  rd_req,
  input  logic [I2C_BYTE_W-1:0] rd_data,
  output logic                  addressed
);

  i2c_state_e            state;
  logic [3:0]            bit_cnt;
  logic [I2C_BYTE_W-1:0] shift;
  logic [I2C_BYTE_W-1:0] shift_nxt;
  logic                  rw;
  logic                  inc_pending;
  logic [1:0]            ld_rd;
  logic                  scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_bus_monitor u_mon (
    .clk       (clk),
    .sync_rst  (sync_rst),
    .clk_en    (clk_en),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda       (sda_s)
  );

  assign shift_nxt = {shift[I2C_BYTE_W-2:0], sda_s};

  always_ff @(posedge clk) begin
    if (!sync_rst) begin
      state       <= ST_IDLE;
      bit_cnt     <= 4'd0;
      shift       <= '0;
      rw          <= 1'b0;
      inc_pending <= 1'b0;
      ld_rd       <= 2'b00;
      sda_oe      <= 1'b0;
      reg_addr    <= '0;
      wr_data     <= '0;
      wr_valid    <= 1'b0;
      rd_req      <= 1'b0;
      addressed   <= 1'b0;
    end else if (clk_en) begin
      wr_valid    <= 1'b0;
      rd_req      <= 1'b0;
      inc_pending <= 1'b0;
      ld_rd       <= {ld_rd[0], 1'b0};
      if (inc_pending) reg_addr <= reg_addr + 8'd1;
      // Read data is sampled one cycle after the requester has had a cycle to respond.
      if (ld_rd[1]) shift <= rd_data;

      if (stop_det || start_det) begin
        state     <= stop_det ? ST_IDLE : ST_DEV_ADDR;
        bit_cnt   <= 4'd0;
        sda_oe    <= 1'b0;
        addressed <= 1'b0;
        ld_rd     <= 2'b00;
      end else begin
        case (state)
          ST_DEV_ADDR, ST_REG_ADDR, ST_WR_DATA: begin
            if (scl_rise) begin
              shift   <= shift_nxt;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= 4'd0;
                if (state == ST_DEV_ADDR) begin
                  if (shift_nxt[7:1] == TARGET_ADDR) begin
                    state <= ST_DEV_ACK;
                    rw    <= shift_nxt[0];
                  end else begin
                    state <= ST_IGNORE;
                  end
                end else if (state == ST_REG_ADDR) begin
                  reg_addr <= shift_nxt;
                  state    <= ST_REG_ACK;
                end else begin
                  wr_data     <= shift_nxt;
                  wr_valid    <= 1'b1;
                  inc_pending <= 1'b1;
                  state       <= ST_WR_ACK;
                end
              end
            end
          end
          ST_DEV_ACK: begin
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe    <= 1'b1;
                addressed <= 1'b1;
              end else begin
                sda_oe <= 1'b0;
                state  <= ST_REG_ADDR;
              end
            end else if (scl_rise && rw) begin
              // The falling edge ending this ACK drives the first read bit.
              rd_req  <= 1'b1;
              ld_rd   <= 2'b01;
              bit_cnt <= 4'd0;
              state   <= ST_RD_DATA;
            end
          end
          ST_REG_ACK, ST_WR_ACK: begin
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else begin
                sda_oe <= 1'b0;
                state  <= ST_WR_DATA;
              end
            end
          end
          ST_RD_DATA: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe  <= 1'b0;
                bit_cnt <= 4'd0;
                state   <= ST_RD_ACK;
              end else begin
                sda_oe  <= ~shift[I2C_BYTE_W-1];
                shift   <= {shift[I2C_BYTE_W-2:0], 1'b0};
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          ST_RD_ACK: begin
            if (scl_rise) begin
              if (!sda_s) begin
                reg_addr <= reg_addr + 8'd1;
                rd_req   <= 1'b1;
                ld_rd    <= 2'b01;
                bit_cnt  <= 4'd0;
                state    <= ST_RD_DATA;
              end else begin
                addressed <= 1'b0;
                state     <= ST_IGNORE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_state_control.sv
// Bench for i2c_target_state_control: a bit-banged controller drives table and corner sequences;
// write and read-request scoreboards compare pushed expectations when the DUT pulses.
module tb_i2c_target_state_control;
  import i2c_pkg::*;

  logic       clk = 1'b0;
  logic       sync_rst = 1'b0;
  logic       clk_en = 1'b0;
  logic       scl_in = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_in;
  logic       sda_oe, wr_valid, rd_req, addressed;
  logic [7:0] reg_addr, wr_data;
  logic [7:0] rd_data = 8'h00;

  assign sda_in = m_sda & ~sda_oe;

  i2c_target_state_control dut (
    .clk       (clk),
    .sync_rst  (sync_rst),
    .clk_en    (clk_en),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .sda_oe    (sda_oe),
    .reg_addr  (reg_addr),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .rd_req    (rd_req),
    .rd_data   (rd_data),
    .addressed (addressed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] dev;
    logic [7:0] regp;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       exp_ack;
    logic [7:0] exp_reg;
  } wvec_t;

  wvec_t       vecs [4];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [15:0] wr_q[$];
  logic [7:0]  rd_q[$];
  logic [15:0] wexp;
  logic [7:0]  rexp;
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  logic        oe_seen = 1'b0;
  logic        wr_prev = 1'b0;
  logic        rd_prev = 1'b0;
  logic        en_div = 1'b0;
  logic        en_force = 1'b0;
  int          en_phase = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // clk_en either forced or 1-of-3 cycles.
  always @(posedge clk) begin
    #1;
    en_phase = (en_phase + 1) % 3;
    clk_en = en_div ? (en_phase == 0) : en_force;
  end

  // Read-data responder: byte returned is reg_addr ^ 0xC3.
  always @(posedge clk) begin
    #1;
    if (rd_req) rd_data = reg_addr ^ 8'hC3;
  end

  always @(negedge clk) begin
    if (sda_oe) oe_seen = 1'b1;
    if (wr_valid && !wr_prev) begin
      wr_cnt++;
      if (wr_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL wr_valid unexpected: got addr 0x%0h data 0x%0h, expected no write", reg_addr, wr_data);
      end else begin
        wexp = wr_q.pop_front();
        check("wr_valid addr/data", 32'({reg_addr, wr_data}), 32'(wexp));
      end
    end
    if (rd_req && !rd_prev) begin
      rd_cnt++;
      if (rd_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL rd_req unexpected: got addr 0x%0h, expected no request", reg_addr);
      end else begin
        rexp = rd_q.pop_front();
        check("rd_req addr", 32'(reg_addr), 32'(rexp));
      end
    end
    wr_prev = wr_valid;
    rd_prev = rd_req;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_x(input logic b, output logic s);
    m_sda = b;
    cyc(7);
    scl_in = 1'b1;
    cyc(7);
    s = sda_in;
    cyc(8);
    scl_in = 1'b0;
    cyc(8);
  endtask

  task automatic start_c();
    m_sda = 1'b1;
    cyc(8);
    scl_in = 1'b1;
    cyc(8);
    m_sda = 1'b0;
    cyc(8);
    scl_in = 1'b0;
    cyc(8);
  endtask

  task automatic stop_c();
    m_sda = 1'b0;
    cyc(8);
    scl_in = 1'b1;
    cyc(8);
    m_sda = 1'b1;
    cyc(8);
  endtask

  task automatic byte_w(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_x(b[i], s);
    bit_x(1'b1, s);
    ack = ~s;
  endtask

  task automatic byte_r(output logic [7:0] b, input logic mack);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_x(1'b1, s);
      b[i] = s;
    end
    bit_x(~mack, s);
  endtask

  task automatic run_vec(input wvec_t v);
    logic       a0, a1, a2, a3;
    logic [7:0] reg1;
    int         rd_base;
    oe_seen = 1'b0;
    rd_base = rd_cnt;
    reg1 = v.regp + 8'd1;
    start_c();
    byte_w(v.dev, a0);
    check("dev addr ack", 32'(a0), 32'(v.exp_ack));
    check("addressed after dev addr", 32'(addressed), 32'(v.exp_ack));
    if (!v.exp_ack) check("state after foreign addr", 32'(dut.state), 32'(ST_IGNORE));
    byte_w(v.regp, a1);
    if (v.exp_ack) wr_q.push_back({v.regp, v.d0});
    byte_w(v.d0, a2);
    if (v.exp_ack) wr_q.push_back({reg1, v.d1});
    byte_w(v.d1, a3);
    check("reg/data acks", 32'({a1, a2, a3}), 32'({3{v.exp_ack}}));
    if (!v.exp_ack) begin
      check("state before stop", 32'(dut.state), 32'(ST_IGNORE));
      check("sda_oe never asserted", 32'(oe_seen), 32'(1'b0));
    end
    stop_c();
    cyc(20);
    check("reg_addr after write", 32'(reg_addr), 32'(v.exp_reg));
    check("state after stop", 32'(dut.state), 32'(ST_IDLE));
    check("addressed after stop", 32'(addressed), 32'(1'b0));
    check("writes outstanding", 32'(wr_q.size()), 32'(0));
    wr_q.delete();
    check("rd_req count in write", 32'(rd_cnt), 32'(rd_base));
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got no end of test, expected finish within 60000 cycles");
    $fatal(1);
  end

  initial begin
    logic       a;
    logic       s;
    logic [7:0] rb;
    int         base;

    vecs[0] = '{8'h84, 8'h10, 8'hA5, 8'h5A, 1'b1, 8'h12};
    vecs[1] = '{8'h86, 8'h20, 8'h11, 8'h22, 1'b0, 8'h12};
    vecs[2] = '{8'h84, 8'hFE, 8'h01, 8'h02, 1'b1, 8'h00};
    vecs[3] = '{8'h84, 8'h7F, 8'h00, 8'hFF, 1'b1, 8'h81};

    // Reset is applied with clk_en held low.
    cyc(4);
    check("reset state", 32'(dut.state), 32'(ST_IDLE));
    check("reset sda_oe", 32'(sda_oe), 32'(1'b0));
    check("reset reg_addr", 32'(reg_addr), 32'(8'h00));
    check("reset wr_data", 32'(wr_data), 32'(8'h00));
    check("reset wr_valid", 32'(wr_valid), 32'(1'b0));
    check("reset rd_req", 32'(rd_req), 32'(1'b0));
    check("reset addressed", 32'(addressed), 32'(1'b0));
    sync_rst = 1'b1;
    en_force = 1'b1;
    cyc(5);

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Register 0xFF write pointer, repeated START, two-byte read with ACK then NACK.
    base = rd_cnt;
    start_c();
    byte_w(8'h84, a);
    check("read: dev W ack", 32'(a), 32'(1'b1));
    byte_w(8'hFF, a);
    check("read: reg ack", 32'(a), 32'(1'b1));
    start_c();
    check("read: addressed after rstart", 32'(addressed), 32'(1'b0));
    rd_q.push_back(8'hFF);
    byte_w(8'h85, a);
    check("read: dev R ack", 32'(a), 32'(1'b1));
    rd_q.push_back(8'h00);
    byte_r(rb, 1'b1);
    check("read: byte 0", 32'(rb), 32'(8'h3C));
    byte_r(rb, 1'b0);
    check("read: byte 1", 32'(rb), 32'(8'hC3));
    check("read: state after NACK", 32'(dut.state), 32'(ST_IGNORE));
    check("read: addressed after NACK", 32'(addressed), 32'(1'b0));
    check("read: rd_req count", 32'(rd_cnt), 32'(base + 2));
    stop_c();
    cyc(20);
    check("read: state after stop", 32'(dut.state), 32'(ST_IDLE));
    check("read: reg_addr wrapped", 32'(reg_addr), 32'(8'h00));

    // STOP after four bits of a data byte.
    base = wr_cnt;
    start_c();
    byte_w(8'h84, a);
    byte_w(8'h30, a);
    check("partial: reg ack", 32'(a), 32'(1'b1));
    bit_x(1'b1, s);
    bit_x(1'b0, s);
    bit_x(1'b1, s);
    bit_x(1'b1, s);
    stop_c();
    cyc(20);
    check("partial: state", 32'(dut.state), 32'(ST_IDLE));
    check("partial: sda_oe", 32'(sda_oe), 32'(1'b0));
    check("partial: no wr_valid", 32'(wr_cnt), 32'(base));
    check("partial: reg_addr", 32'(reg_addr), 32'(8'h30));

    // Reset while the target is pulling SDA low during a read (0x10 ^ 0xC3 = 0xD3, third bit 0).
    start_c();
    byte_w(8'h84, a);
    byte_w(8'h10, a);
    start_c();
    rd_q.push_back(8'h10);
    byte_w(8'h85, a);
    bit_x(1'b1, s);
    bit_x(1'b1, s);
    check("rst-read: sda_oe driving 0 bit", 32'(sda_oe), 32'(1'b1));
    sync_rst = 1'b0;
    cyc(1);
    check("rst-read: sda_oe released", 32'(sda_oe), 32'(1'b0));
    check("rst-read: state", 32'(dut.state), 32'(ST_IDLE));
    sync_rst = 1'b1;
    cyc(2);
    rd_q.delete();
    stop_c();
    cyc(10);
    run_vec(vecs[0]);

    // Same table with clk_en active one cycle in three.
    en_div = 1'b1;
    for (int i = 0; i < 4; i++) run_vec(vecs[i]);
    en_div = 1'b0;
    cyc(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_target_state_control.md
I2C_TARGET_STATE_CONTROL -- requirements
Module: i2c_target_state_control

Interface
REQ-001 Parameter TARGET_ADDR, default 7'h42, 7-bit bus address this target responds to.
REQ-002 clk  input  1  sole clock; all logic rising-edge.
REQ-003 sync_rst  input  1  reset, synchronous, active-low.
REQ-004 clk_en  input  1  global enable; when low all state, counters and outputs hold.
REQ-005 scl_in  input  1  raw bus SCL, asynchronous.
REQ-006 sda_in  input  1  raw bus SDA, asynchronous.
REQ-007 sda_oe  output  1  high = pull SDA low (open-drain); low = release.
REQ-008 reg_addr  output  8  current register pointer.
REQ-009 wr_valid  output  1  one-cycle pulse; wr_data is valid for reg_addr.
REQ-010 wr_data  output  8  received data byte.
REQ-011 rd_req  output  1  one-cycle pulse requesting rd_data for reg_addr.
REQ-012 rd_data  input  8  read byte; valid the cycle after rd_req.
REQ-013 addressed  output  1  high from address ACK until STOP, repeated START or NACK-terminated read.

Function
REQ-014 SCL/SDA SHALL pass a 2-flop synchronizer; all edge and condition detection uses synchronized values.
REQ-015 START = synced SDA falls while synced SCL high; STOP = synced SDA rises while synced SCL high.
REQ-016 Data bits SHALL be sampled on SCL rising edges, MSB first; sda_oe SHALL change only on SCL falling edges.
REQ-017 States: IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
REQ-018 IDLE -> DEV_ADDR on START; a START in any state, including a repeated START, SHALL enter DEV_ADDR with bit count cleared and sda_oe low.
REQ-019 STOP in any state -> IDLE with sda_oe low and addressed low.
REQ-020 After 8 DEV_ADDR bits: if bits[7:1] == TARGET_ADDR -> DEV_ACK; otherwise -> IGNORE, and sda_oe stays low.
REQ-021 ACK: sda_oe asserts on the SCL falling edge after bit 8 and releases on the SCL falling edge after bit 9.
REQ-022 After DEV_ACK with R/W=0 -> REG_ADDR. After REG_ADDR: reg_addr is loaded, then REG_ACK -> WR_DATA.
REQ-023 After 8 WR_DATA bits: wr_data is updated and wr_valid pulses for one cycle with the pre-increment reg_addr. The block then enters WR_ACK, and reg_addr increments one cycle after wr_valid.
REQ-024 After DEV_ACK with R/W=1: rd_req pulses on the SCL rising edge of the 9th bit. rd_data is latched into the shift register the next cycle. -> RD_DATA.
REQ-025 In RD_DATA, on each SCL falling edge sda_oe = ~current bit, MSB first. The first bit is driven on the falling edge that ends the ACK. After 8 bits sda_oe releases -> RD_ACK.
REQ-026 RD_ACK samples the controller's bit on SCL rising. 0: reg_addr increments, rd_req pulses, -> RD_DATA. 1 (NACK): -> IGNORE, addressed low.
REQ-027 reg_addr arithmetic is 8-bit modulo; 8'hFF increments to 8'h00.
REQ-028 IGNORE leaves only on START or STOP.
REQ-029 A STOP or START arriving mid-byte discards the partial byte and produces no wr_valid.
REQ-030 With clk_en low, edge detection is suspended: synchronizer and edge-history registers hold.

Reset
REQ-031 While sync_rst is low at a clk edge: state=IDLE, bit count=0, sda_oe=0, reg_addr=8'h00, wr_data=8'h00, wr_valid=0, rd_req=0, addressed=0, synchronizer flops=1. This applies regardless of clk_en.
REQ-032 A reset asserted mid-transaction SHALL release SDA within one cycle and wait for a fresh START.

Structure
REQ-033 Shared package i2c_pkg holds the state enum typedef, I2C_ADDR_W=7 and I2C_BYTE_W=8; the initiator-side state control shares it.
REQ-034 Sub-module i2c_bus_monitor contains the synchronizer, SCL rise/fall detection and START/STOP detection, and outputs single-cycle pulses.

Verification
REQ-035 Write 0x84 (addr 0x42, W), reg 0x10, data 0xA5, 0x5A, STOP -> ACK on all three bytes; wr_valid with (0x10,0xA5), then (0x11,0x5A); reg_addr=0x12.
REQ-036 Address 0x43 W -> no sda_oe at any point; state IGNORE until STOP; no wr_valid or rd_req.
REQ-037 Write reg 0xFF, repeated START, addr 0x85 (R) with rd_data 0x3C then 0xC3, controller ACK then NACK, STOP -> rd_req at 0xFF and 0x00; SDA bits match 0x3C and 0xC3; IGNORE after NACK.
REQ-038 STOP after 4 bits of a WR_DATA byte -> IDLE; no wr_valid; sda_oe=0.
REQ-039 sync_rst low during RD_DATA while sda_oe=1 -> sda_oe=0 next cycle, IDLE; the following full write transaction succeeds.
REQ-040 clk_en toggled 1-of-3 cycles with SCL period 30 clk throughout REQ-035 -> identical results.
